aes_key_schedule: RTL and testbench
===================================

Name: aes_key_schedule

Overview:
- Iterative AES-128 key expansion engine, directly upstream of the round datapath; supplies the 128-bit key consumed by every round instance.
- Accepts a cipher key, computes round keys 1..10 at one per clock, and stores all 11 round keys (0..10) in an internal bank.
- The round controller reads any stored key by index.

Parameters:
- NR, 10, number of rounds. Fixed for AES-128; other values are unsupported.
- KEY_W, 128, key and round-key width in bits.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- key_in  in  128  cipher key. Byte 0 is at [127:120]; word w0 is [127:96].
- key_load  in  1  single-cycle strobe that starts expansion of key_in.
- busy  out  1  high while expansion is in progress.
- keys_ready  out  1  high when round keys 0..10 are all valid.
- rd_idx  in  4  round-key index to read, 0..10.
- rd_key  out  128  registered round key selected by rd_idx.

Behaviour:
- Reset (rst sampled high at a rising edge):
  - FSM goes to IDLE.
  - busy=0, keys_ready=0, rd_key=0.
  - All 11 bank entries cleared to 0.
  - Round counter=0, rcon=8'h01.
  - Reset during EXPAND aborts expansion; no partial keys are flagged valid.
- FSM states: IDLE, EXPAND, DONE.
  - IDLE/DONE with key_load=1 at edge E0:
    - bank[0]<=key_in, counter<=1, rcon<=8'h01.
    - keys_ready<=0, busy<=1, state<=EXPAND.
  - EXPAND, at each edge Ek (k=1..10):
    - bank[k]<=f(bank[k-1], rcon); rcon<=xtime(rcon); counter<=k+1.
    - At E10: state<=DONE, busy<=0, keys_ready<=1.
  - key_load while in EXPAND is ignored. Expansion continues with the original key; there is no restart.
- Latency: keys_ready rises 10 clocks after the edge that sampled key_load. A new key_load in DONE drops keys_ready on the next edge.
- Expansion function f, with previous words w0..w3 taken MSB-first:
  - t = SubWord(RotWord(w3)) ^ {rcon,24'h0}.
  - RotWord(x) = {x[23:0], x[31:24]}.
  - SubWord applies the AES S-box to each of the 4 bytes.
  - n0=w0^t, n1=w1^n0, n2=w2^n1, n3=w3^n2.
  - Result is {n0,n1,n2,n3}.
- rcon sequence: 01,02,04,08,10,20,40,80,1B,36.
  - xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1B : 8'h00).
- Read port:
  - rd_key <= bank[rd_idx] every cycle, 1-cycle latency, independent of FSM state.
  - rd_idx 11..15 returns 128'h0.
  - A read of entry k during EXPAND returns the stale value until bank[k] has been written.
  - A read and a write of the same entry in the same cycle returns the old value.
- rd_key contents are only guaranteed meaningful while keys_ready=1.

Decomposition:
- Shared package aes_pkg holds:
  - localparams NR=10 and KEY_W=128.
  - FSM state typedef.
  - RCON constant table, used for checking.
  - xtime function.
  - The S-box lookup function, shared with the subbytes stage.
- One sub-module, aes_sub_word: combinational 32-bit SubWord, built from 4 S-box lookups.

Test Plan:
- FIPS-197 App. A key 2b7e1516_28aed2a6_abf71588_09cf4f3c, pulse key_load:
  - keys_ready rises exactly 10 clocks later.
  - rd_idx=1 gives a0fafe17_88542cb1_23a33939_2a6c7605.
  - rd_idx=10 gives d014f9a8_c9ee2589_e13f0cc8_b6630ca6.
  - rd_idx=0 returns the cipher key.
- All-zero key:
  - rd_idx=1 gives 62636363_62636363_62636363_62636363.
  - rd_idx=10 gives b4ef5bcb_3e92e211_23e951cf_6f8f188e.
- key_load of key B in cycle 4 of expansion of key A:
  - Completes with A's keys; keys_ready timing unchanged.
  - A subsequent key_load of B in DONE produces B's schedule.
- rst asserted at cycle 5 of EXPAND:
  - Next cycle: busy=0, keys_ready=0, rd_key=0.
  - Every rd_idx reads 0.
  - A fresh key_load then completes normally.
- rd_idx sweep 0..15 in DONE:
  - Each value appears one cycle after its index.
  - Indices 11..15 read 0.
- Back-to-back key_load in DONE on consecutive cycles:
  - The second strobe is ignored because the FSM is in EXPAND.
  - keys_ready is low for exactly 10 cycles.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule definitions: sizes, FSM states, round constants,
// xtime and the forward S-box.
package aes_pkg;

    localparam int NR    = 10;
    localparam int KEY_W = 128;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DONE   = 2'd2
    } ks_state_t;

    localparam logic [0:9][7:0] RCON = {
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[x];
    endfunction

endpackage

// File: rtl/aes_key_schedule_if.sv
// Control/read bus of the key-schedule engine; master is the round controller.
interface aes_key_schedule_if;
    import aes_pkg::*;

    logic [KEY_W-1:0] key_in;
    logic             key_load;
    logic             busy;
    logic             keys_ready;
    logic [3:0]       rd_idx;
    logic [KEY_W-1:0] rd_key;

    modport master (output key_in, key_load, rd_idx, input busy, keys_ready, rd_key);
    modport slave  (input key_in, key_load, rd_idx, output busy, keys_ready, rd_key);

endinterface

// File: rtl/aes_sub_word.sv
// Combinational AES SubWord: S-box applied to each byte of a 32-bit word.
module aes_sub_word
    import aes_pkg::*;
(
    input  logic [31:0] word,
    output logic [31:0] sub
);

    assign sub = {sbox(word[31:24]), sbox(word[23:16]), sbox(word[15:8]), sbox(word[7:0])};

endmodule

// File: rtl/aes_key_schedule.sv
// Iterative AES-128 key expansion into an 11-entry bank, one round key per clock;
// keys_ready 10 clocks after key_load, key_load ignored while busy, 1-cycle registered read.
module aes_key_schedule
    import aes_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    aes_key_schedule_if.slave   bus
);

    localparam logic [3:0] LAST = 4'(NR);

    ks_state_t        state;
    ks_state_t        state_next;
    logic             start;
    logic [KEY_W-1:0] bank [0:NR];
    logic [3:0]       cnt;
    logic [7:0]       rcon;
    logic [KEY_W-1:0] prev_key;
    logic [KEY_W-1:0] next_key;
    logic [31:0]      rot;
    logic [31:0]      sub;
    logic [31:0]      t;
    logic [31:0]      n0, n1, n2, n3;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        start      = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (bus.key_load) begin
                    start      = 1'b1;
                    state_next = EXPAND;
                end
            end
            EXPAND:  if (cnt == LAST) state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    assign bus.busy       = (state == EXPAND);
    assign bus.keys_ready = (state == DONE);

    always_comb begin
        prev_key = '0;
        if (cnt >= 4'd1 && cnt <= LAST) prev_key = bank[cnt - 4'd1];
    end

    assign rot = {prev_key[23:0], prev_key[31:24]};

    aes_sub_word u_sub_word (
        .word (rot),
        .sub  (sub)
    );

    assign t        = sub ^ {rcon, 24'h0};
    assign n0       = prev_key[127:96] ^ t;
    assign n1       = prev_key[95:64]  ^ n0;
    assign n2       = prev_key[63:32]  ^ n1;
    assign n3       = prev_key[31:0]   ^ n2;
    assign next_key = {n0, n1, n2, n3};

    // Reads see the bank before this edge's write, so a same-entry read returns the old key.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= NR; i++) bank[i] <= '0;
            cnt        <= 4'd0;
            rcon       <= 8'h01;
            bus.rd_key <= '0;
        end else begin
            bus.rd_key <= (bus.rd_idx <= LAST) ? bank[bus.rd_idx] : '0;
            if (start) begin
                bank[0] <= bus.key_in;
                cnt     <= 4'd1;
                rcon    <= 8'h01;
            end else if (state == EXPAND) begin
                assert (rcon == RCON[cnt - 4'd1]);
                bank[cnt] <= next_key;
                rcon      <= xtime(rcon);
                cnt       <= cnt + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_aes_key_schedule.sv
// Directed bench for the AES-128 key schedule using FIPS-197 and all-zero key vectors.
module tb_aes_key_schedule;
    import aes_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    aes_key_schedule_if kif();

    aes_key_schedule dut (
        .clk (clk),
        .rst (rst),
        .bus (kif)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int n_cyc;

    localparam logic [127:0] KEY_A = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
    localparam logic [127:0] KEY_Z = 128'h0;
    localparam logic [127:0] Z_R1  = 128'h62636363_62636363_62636363_62636363;
    localparam logic [127:0] Z_R10 = 128'hb4ef5bcb_3e92e211_23e951cf_6f8f188e;

    logic [127:0] exp_a [0:10] = '{
        128'h2b7e1516_28aed2a6_abf71588_09cf4f3c,
        128'ha0fafe17_88542cb1_23a33939_2a6c7605,
        128'hf2c295f2_7a96b943_5935807a_7359f67f,
        128'h3d80477d_4716fe3e_1e237e44_6d7a883b,
        128'hef44a541_a8525b7f_b671253b_db0bad00,
        128'hd4d1c6f8_7c839d87_caf2b8bc_11f915bc,
        128'h6d88a37a_110b3efd_dbf98641_ca0093fd,
        128'h4e54f70e_5f5fc9f3_84a64fb2_4ea6dc4f,
        128'head27321_b58dbad2_312bf560_7f8d292f,
        128'hac7766f3_19fadc21_28d12941_575c006e,
        128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6
    };

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic load_key(input logic [127:0] key);
        kif.key_in   = key;
        kif.key_load = 1'b1;
        step();
        kif.key_load = 1'b0;
    endtask

    // Counts edges after the load edge until keys_ready; optionally strobes key_load
    // with a second key on the edge numbered inject_at (0 = the very next edge).
    task automatic wait_ready(input int inject_at, input logic [127:0] inject_key, output int n);
        n = 21;
        for (int i = 0; i < 20; i++) begin
            if (i == inject_at) begin
                kif.key_in   = inject_key;
                kif.key_load = 1'b1;
            end
            step();
            kif.key_load = 1'b0;
            if (kif.keys_ready) begin
                n = i + 1;
                break;
            end
        end
    endtask

    task automatic read_chk(input logic [3:0] idx, input logic [127:0] exp, input string tag);
        kif.rd_idx = idx;
        step();
        check(tag, kif.rd_key, exp);
    endtask

    initial begin
        rst          = 1'b1;
        kif.key_in   = '0;
        kif.key_load = 1'b0;
        kif.rd_idx   = 4'd0;
        step();
        step();
        check("rst_busy", 128'(kif.busy), 128'd0);
        check("rst_ready", 128'(kif.keys_ready), 128'd0);
        check("rst_rd_key", kif.rd_key, 128'd0);
        rst = 1'b0;

        // FIPS-197 key
        load_key(KEY_A);
        check("a_busy", 128'(kif.busy), 128'd1);
        check("a_ready_low", 128'(kif.keys_ready), 128'd0);
        wait_ready(-1, KEY_A, n_cyc);
        check("a_latency", 128'(n_cyc), 128'd10);
        check("a_busy_done", 128'(kif.busy), 128'd0);
        read_chk(4'd1, exp_a[1], "a_r1");
        read_chk(4'd10, exp_a[10], "a_r10");
        read_chk(4'd0, KEY_A, "a_r0");

        // All-zero key
        load_key(KEY_Z);
        check("z_ready_drop", 128'(kif.keys_ready), 128'd0);
        wait_ready(-1, KEY_Z, n_cyc);
        check("z_latency", 128'(n_cyc), 128'd10);
        read_chk(4'd1, Z_R1, "z_r1");
        read_chk(4'd10, Z_R10, "z_r10");
        read_chk(4'd0, KEY_Z, "z_r0");

        // Load of key B during expansion of key A is ignored
        load_key(KEY_A);
        wait_ready(3, KEY_Z, n_cyc);
        check("mid_latency", 128'(n_cyc), 128'd10);
        read_chk(4'd1, exp_a[1], "mid_r1");
        read_chk(4'd10, exp_a[10], "mid_r10");
        load_key(KEY_Z);
        check("b_ready_drop", 128'(kif.keys_ready), 128'd0);
        wait_ready(-1, KEY_Z, n_cyc);
        check("b_latency", 128'(n_cyc), 128'd10);
        read_chk(4'd10, Z_R10, "b_r10");

        // Reset in the middle of expansion
        kif.rd_idx = 4'd0;
        load_key(KEY_A);
        for (int i = 0; i < 4; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_busy", 128'(kif.busy), 128'd0);
        check("abort_ready", 128'(kif.keys_ready), 128'd0);
        check("abort_rd_key", kif.rd_key, 128'd0);
        for (int i = 0; i < 16; i++) read_chk(4'(i), 128'd0, $sformatf("abort_idx_%0d", i));
        load_key(KEY_A);
        wait_ready(-1, KEY_A, n_cyc);
        check("abort_reload_latency", 128'(n_cyc), 128'd10);

        // Full index sweep in DONE
        for (int i = 0; i < 16; i++)
            read_chk(4'(i), (i <= 10) ? exp_a[i] : 128'd0, $sformatf("sweep_%0d", i));

        // Back-to-back strobes: second one (key A) lands in EXPAND and is ignored
        load_key(KEY_Z);
        wait_ready(0, KEY_A, n_cyc);
        check("b2b_low_cycles", 128'(n_cyc), 128'd10);
        read_chk(4'd1, Z_R1, "b2b_r1");
        read_chk(4'd10, Z_R10, "b2b_r10");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
